// File: rtl/generic_intf_pkg.sv
// Shared types and the cyclic priority-pick helper for the generic_intf arbiter.
package generic_intf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Widest requester vector the helper can scan; callers zero-extend into it.
    localparam int RR_MAX = 32;
    localparam int RR_IW  = 5;

    typedef struct packed {
        logic             found;
        logic [RR_IW-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, scanning cyclically over n entries.
    // The loop runs from the farthest offset down so the nearest hit is the one kept.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [RR_IW-1:0]  ptr,
                                         input logic [RR_IW:0]    n);
        rr_pick_t         r;
        logic [RR_IW:0]   j;
        r = '0;
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            j = {1'b0, ptr} + (RR_IW + 1)'(i);
            if (j >= n) j = j - n;
            if (((RR_IW + 1)'(i) < n) && req[j[RR_IW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[RR_IW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/generic_intf.sv
// Single-producer streaming link: one data word plus a valid strobe.
interface generic_intf #(
    parameter type T = logic [7:0]
);
    T     data;
    logic valid;

    modport producer (output data, output valid);
    modport consumer (input data, input valid);
endinterface

// File: rtl/generic_rr_pick.sv
// Combinational cyclic priority picker: lowest-offset request at or after ptr.
module generic_rr_pick
    import generic_intf_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    rr_pick_t r;
    logic     unused_idx_hi;

    if (N > RR_MAX) begin : g_chk_width
        $error("generic_rr_pick: N exceeds RR_MAX");
    end

    // Scan the zero-extended request vector from ptr.
    always_comb begin
        r = rr_pick(RR_MAX'(req), RR_IW'(ptr), (RR_IW + 1)'(N));
    end

    assign found         = r.found;
    assign idx           = r.idx[PW-1:0];
    assign unused_idx_hi = |(r.idx >> PW);

endmodule

// File: rtl/generic_intf_arbiter.sv
// Round-robin burst arbiter: shares one generic_intf producer port among N_REQ requesters.
// A grant lasts until the owner's last beat, MAX_BURST beats, or the owner drops req;
// the next owner is picked in the same cycle so back-to-back bursts have no bubble.
module generic_intf_arbiter
    import generic_intf_pkg::*;
#(
    parameter type T         = logic [7:0],
    parameter int  N_REQ     = 4,
    parameter int  MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  T                         data_i [N_REQ],
    input  logic [N_REQ-1:0]         last_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic                     busy_o,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    generic_intf.producer            bus
);

    localparam int OW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0] OWNER_MAX = OW'(N_REQ - 1);
    localparam logic [BW-1:0] CNT_LAST  = BW'(MAX_BURST - 1);

    if (N_REQ < 2) begin : g_chk_nreq
        $error("generic_intf_arbiter: N_REQ must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_chk_burst
        $error("generic_intf_arbiter: MAX_BURST must be >= 1");
    end

    arb_state_e    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic [OW-1:0] owner_inc;
    logic [OW-1:0] pick_ptr;
    logic [OW-1:0] pick_idx;
    logic          pick_found;
    logic          own_req;
    logic          own_last;
    logic          beat;
    logic          rel;

    T     bus_data_p1;
    logic bus_vld_p1;

    assign owner_inc = (owner_q == OWNER_MAX) ? '0 : owner_q + OW'(1);
    assign own_req   = req_i[owner_q];
    assign own_last  = last_i[owner_q];
    assign beat      = (state_q == BUSY) && own_req;
    // Release on abandon, on a last beat, or on the final beat the burst limit allows.
    assign rel       = (state_q == BUSY) &&
                       (!own_req || own_last || (beat_cnt_q == CNT_LAST));

    // While idle, search from rr_ptr; while busy, the search serves the release path.
    assign pick_ptr  = (state_q == BUSY) ? owner_inc : rr_ptr_q;

    generic_rr_pick #(
        .N  (N_REQ),
        .PW (OW)
    ) u_pick (
        .req   (req_i),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state, owner, beat counter and round-robin pointer.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BUSY;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                if (rel) begin
                    rr_ptr_d = owner_inc;
                    if (pick_found) begin
                        owner_d    = pick_idx;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Bus output register: forward each beat; data holds between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_vld_p1  <= 1'b0;
            bus_data_p1 <= '0;
        end else begin
            bus_vld_p1 <= beat;
            if (beat) bus_data_p1 <= data_i[owner_q];
        end
    end

    // Grant is a decode of the registered owner so it follows reset immediately.
    always_comb begin
        gnt_o = '0;
        if (state_q == BUSY) gnt_o[owner_q] = 1'b1;
    end

    assign busy_o    = (state_q == BUSY);
    assign owner_o   = owner_q;
    assign bus.valid = bus_vld_p1;
    assign bus.data  = bus_data_p1;

endmodule

// File: tb/tb_generic_intf_arbiter.sv
// Randomised bench for generic_intf_arbiter with a behavioural reference model.
module tb_generic_intf_arbiter;

    localparam int N  = 4;
    localparam int MB = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic [7:0]   data [N];
    logic [N-1:0] gnt;
    logic         busy;
    logic [1:0]   owner;

    int n_checks;
    int n_errors;

    // Reference model state.
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_beats;
    bit         m_valid;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    generic_intf #(.T(logic [7:0])) bus_if ();

    generic_intf_arbiter #(
        .T         (logic [7:0]),
        .N_REQ     (N),
        .MAX_BURST (MB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .data_i  (data),
        .last_i  (last),
        .gnt_o   (gnt),
        .busy_o  (busy),
        .owner_o (owner),
        .bus     (bus_if)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_beats = 0;
        m_valid = 0;
        m_data  = 8'h00;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        int w;
        bit b;
        bit done;
        if (!m_busy) begin
            m_valid = 0;
            w = first_from(req, m_ptr);
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
                m_beats = 0;
            end
        end else begin
            b = req[m_owner];
            m_valid = b;
            if (b) begin
                m_data  = data[m_owner];
                m_beats = m_beats + 1;
            end
            done = !b || last[m_owner] || (m_beats == MB);
            if (done) begin
                m_ptr = (m_owner + 1) % N;
                w = first_from(req, m_ptr);
                if (w >= 0) begin
                    m_owner = w;
                    m_beats = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        check_val("gnt", 32'(gnt), 32'(eg));
        check_val("busy", 32'(busy), 32'(m_busy));
        if (m_busy) check_val("owner", 32'(owner), 32'(m_owner));
        check_val("bus_valid", 32'(bus_if.valid), 32'(m_valid));
        check_val("bus_data", 32'(bus_if.data), 32'(m_data));
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic tick();
        #1;
        compare_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic gen(input int mode);
        for (int i = 0; i < N; i++) data[i] = 8'($urandom_range(255));
        case (mode)
            0: begin
                req  = N'($urandom_range(15) & $urandom_range(15));
                last = N'($urandom_range(15));
            end
            1: begin
                req  = '1;
                last = N'(($urandom_range(7) == 0) ? $urandom_range(15) : 0);
            end
            2: begin
                req  = '1;
                last = '1;
            end
            3: begin
                req  = 4'b1010;
                last = '0;
            end
            default: begin
                req  = N'($urandom_range(15) | $urandom_range(15));
                last = N'($urandom_range(15) & $urandom_range(15));
            end
        endcase
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        for (int i = 0; i < N; i++) data[i] = 8'h00;
        model_reset();

        // Held in reset with requests toggling: nothing may be granted.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req = (c % 2 == 0) ? 4'hF : 4'h0;
            #1;
            check_val("rst_gnt", 32'(gnt), 32'h0);
            check_val("rst_valid", 32'(bus_if.valid), 32'h0);
            check_val("rst_busy", 32'(busy), 32'h0);
        end
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;

        // Single burst from requester 2: 10,11,12,13 with last on 13.
        req = 4'b0100; data[2] = 8'h10; last = '0; tick();
        data[2] = 8'h10; tick();
        data[2] = 8'h11; tick();
        data[2] = 8'h12; tick();
        data[2] = 8'h13; last = 4'b0100; tick();
        req = '0; last = '0; tick();
        check_val("single_last_data", 32'(bus_if.data), 32'h13);
        repeat (2) tick();

        // Everyone requesting with last on every beat: grants rotate.
        repeat (10) begin gen(2); tick(); end
        req = '0; last = '0; repeat (2) tick();

        // Requester 1 streams without last while 3 waits: burst limit forces handover.
        repeat (20) begin gen(3); tick(); end
        req = '0; last = '0; repeat (2) tick();

        // Reset in the middle of a burst.
        repeat (5) begin gen(3); tick(); end
        gen(3);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_gnt", 32'(gnt), 32'h0);
        check_val("midrst_valid", 32'(bus_if.valid), 32'h0);
        check_val("midrst_busy", 32'(busy), 32'h0);
        check_val("midrst_data", 32'(bus_if.data), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1010; last = '0; tick();
        tick();
        check_val("post_rst_gnt", 32'(gnt), 32'h2);

        // Randomised traffic of varying density.
        for (int m = 0; m < 5; m++) begin
            repeat (200) begin gen(m == 3 ? 4 : m); tick(); end
        end
        repeat (300) begin gen($urandom_range(4)); tick(); end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
